// File: rtl/niossys_nios2_ocimem_ctrl_if.sv
// niossys_nios2_ocimem_ctrl_if: Avalon-MM slave bus used by the CPU to reach the OCI debug RAM
interface niossys_nios2_ocimem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/niossys_nios2_ocimem_ctrl.sv
// niossys_nios2_ocimem_ctrl: JTAG OCI-memory command decoder and CPU Avalon slave sharing one debug RAM
// Optional feature: define OCIMEM_WRITE_PROTECT_EN to make the first PROT_WORDS words read-only.
module niossys_nios2_ocimem_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int PROT_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    niossys_nios2_ocimem_ctrl_if.slave avs
);
    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DONE, WR} state_t;

    state_t            state, next_state;
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] mon_areg;
    logic [31:0]       wr_data;
    logic              rd_pend;
    logic              idle, strobe_any, jtag_busy;
    logic              rd_start, wr_start, err_set, err_clr;
    logic              cpu_wr_grant, cpu_rd_grant;
    logic              jtag_prot, cpu_prot;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wd;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

`ifdef OCIMEM_WRITE_PROTECT_EN
    assign jtag_prot = $unsigned(32'(mon_areg)) < $unsigned(32'(PROT_WORDS));
    assign cpu_prot  = $unsigned(32'(avs.avs_address)) < $unsigned(32'(PROT_WORDS));
`else
    assign jtag_prot = 1'b0;
    assign cpu_prot  = 1'b0;
`endif

    assign idle       = state == IDLE;
    assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jtag_busy  = !idle | strobe_any;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next state and command decode; strobe a outranks no_action_a, and both outrank b
    always_comb begin
        next_state = state;
        rd_start   = 1'b0;
        wr_start   = 1'b0;
        case (state)
            IDLE: begin
                rd_start   = take_action_ocimem_a ? jdo[35] : take_no_action_ocimem_a;
                wr_start   = take_action_ocimem_b & !take_action_ocimem_a & !take_no_action_ocimem_a;
                next_state = rd_start ? RD_ISSUE : wr_start ? WR : IDLE;
            end
            RD_ISSUE: next_state = RD_DONE;
            RD_DONE:  next_state = IDLE;
            WR:       next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Error sources, CPU arbitration and the shared RAM port mux (JTAG owns RAM outside IDLE)
    always_comb begin
        err_set = (!idle & strobe_any)
                | (idle & take_action_ocimem_b & (take_action_ocimem_a | take_no_action_ocimem_a))
                | (state == WR & jtag_prot);
        err_clr = idle & take_action_ocimem_a & jdo[25];
        cpu_wr_grant = avs.avs_write & !jtag_busy;
        cpu_rd_grant = avs.avs_read & !avs.avs_write & !rd_pend & !jtag_busy;
        avs.avs_waitrequest = avs.avs_write ? jtag_busy : avs.avs_read & !rd_pend;
        ram_addr = idle ? avs.avs_address : mon_areg;
        ram_we   = (state == WR & !jtag_prot) | (cpu_wr_grant & !cpu_prot);
        ram_be   = idle ? avs.avs_byteenable : 4'hF;
        ram_wd   = idle ? avs.avs_writedata : wr_data;
    end

    // Debug RAM write port with byte lanes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we && ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
    end

    // Monitor registers, synchronous RAM reads and CPU read handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_areg          <= '0;
            MonDReg           <= '0;
            monitor_ready     <= 1'b0;
            monitor_error     <= 1'b0;
            wr_data           <= '0;
            avs.avs_readdata  <= '0;
            rd_pend           <= 1'b0;
        end else begin
            if (idle & take_action_ocimem_a & jdo[34]) mon_areg <= jdo[26 +: ADDR_W];
            else if (state == RD_ISSUE || state == WR) mon_areg <= mon_areg + ADDR_W'(1);
            if (rd_start | wr_start) monitor_ready <= 1'b0;
            else if (state == RD_ISSUE || state == WR) monitor_ready <= 1'b1;
            if (state == RD_ISSUE) MonDReg <= mem[ram_addr];
            if (wr_start) wr_data <= jdo[34:3];
            monitor_error <= err_set | (monitor_error & !err_clr);
            if (cpu_rd_grant) avs.avs_readdata <= mem[ram_addr];
            rd_pend <= cpu_rd_grant;
        end
    end
endmodule

// File: tb/tb_niossys_nios2_ocimem_ctrl.sv
// tb_niossys_nios2_ocimem_ctrl: directed table-driven bench for the OCI debug RAM controller
module tb_niossys_nios2_ocimem_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_a = 1'b0;
    logic        take_b = 1'b0;
    logic        take_na = 1'b0;
    logic [31:0] mon_dreg;
    logic        mon_ready, mon_error;
    int          n_chk = 0;
    int          n_err = 0;

    niossys_nios2_ocimem_ctrl_if #(.ADDR_W(8)) bus ();

    niossys_nios2_ocimem_ctrl #(.ADDR_W(8), .PROT_WORDS(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .MonDReg                 (mon_dreg),
        .monitor_ready           (mon_ready),
        .monitor_error           (mon_error),
        .avs                     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [37:0] mk_a(input logic rd, input logic ld, input logic clr, input logic [7:0] addr);
        logic [37:0] j;
        j = '0;
        j[35] = rd;
        j[34] = ld;
        j[25] = clr;
        j[33:26] = addr;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic str_a(input logic [37:0] j);
        jdo = j;
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
    endtask

    task automatic str_b(input logic [31:0] d);
        jdo = mk_b(d);
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
    endtask

    task automatic str_na();
        take_na = 1'b1;
        tick();
        take_na = 1'b0;
    endtask

    task automatic jwrite(input logic [7:0] a, input logic [31:0] d);
        str_a(mk_a(1'b0, 1'b1, 1'b0, a));
        str_b(d);
        tick();
    endtask

    task automatic jread(input logic [7:0] a, output logic [31:0] d);
        str_a(mk_a(1'b1, 1'b1, 1'b0, a));
        tick();
        d = mon_dreg;
        tick();
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int cyc);
        bus.avs_address = a;
        bus.avs_read = 1'b1;
        cyc = 0;
        d = 'x;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest) begin
                d = bus.avs_readdata;
                break;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.avs_read = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.avs_address = a;
        bus.avs_writedata = d;
        bus.avs_byteenable = be;
        bus.avs_write = 1'b1;
        @(negedge clk);
        chk("cpu_write_wait", 32'(bus.avs_waitrequest), 0);
        @(posedge clk);
        #1;
        bus.avs_write = 1'b0;
    endtask

    initial begin
        logic [31:0] d, v0;
        int cyc;
        tbl[0] = '{8'h40, 32'hA5A5_0001};
        tbl[1] = '{8'h41, 32'h0000_0000};
        tbl[2] = '{8'h7F, 32'hFFFF_FFFF};
        tbl[3] = '{8'h80, 32'h1357_9BDF};
        tbl[4] = '{8'hA5, 32'h8000_0001};
        tbl[5] = '{8'hFE, 32'h2468_ACE0};
        bus.avs_address = '0;
        bus.avs_read = 1'b0;
        bus.avs_write = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_byteenable = 4'hF;
        #22 reset_n = 1'b1;
        tick();
        chk("rst_mondreg", mon_dreg, 0);
        chk("rst_ready", 32'(mon_ready), 0);
        chk("rst_error", 32'(mon_error), 0);
        chk("rst_readdata", bus.avs_readdata, 0);
        chk("rst_wait", 32'(bus.avs_waitrequest), 0);

        str_a(mk_a(1'b0, 1'b1, 1'b0, 8'h10));
        chk("ld_only_ready", 32'(mon_ready), 0);
        str_b(32'hDEAD_BEEF);
        chk("wr_ready_t1", 32'(mon_ready), 0);
        tick();
        chk("wr_ready_t2", 32'(mon_ready), 1);
        chk("wr_areg", 32'(dut.mon_areg), 32'h11);
        str_b(32'hCAFE_F00D);
        tick();

        str_a(mk_a(1'b1, 1'b1, 1'b0, 8'h10));
        chk("rd_ready_t1", 32'(mon_ready), 0);
        chk("rd_dreg_t1", mon_dreg, 0);
        tick();
        chk("rd_dreg_t2", mon_dreg, 32'hDEAD_BEEF);
        chk("rd_ready_t2", 32'(mon_ready), 1);
        tick();
        str_na();
        tick();
        chk("na_dreg", mon_dreg, 32'hCAFE_F00D);
        tick();
        chk("na_areg", 32'(dut.mon_areg), 32'h12);

        jwrite(8'hFF, 32'h1);
        str_b(32'h2);
        tick();
        chk("wrap_areg", 32'(dut.mon_areg), 32'h01);
        chk("wrap_error", 32'(mon_error), 0);
        jread(8'hFF, d);
        chk("wrap_ff", d, 32'h1);
        str_na();
        tick();
        chk("wrap_00", mon_dreg, 32'h2);
        tick();

        str_a(mk_a(1'b1, 1'b1, 1'b0, 8'h10));
        jdo = mk_b(32'h1111_1111);
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        chk("busy_b_error", 32'(mon_error), 1);
        tick();
        jread(8'h11, d);
        chk("busy_b_dropped", d, 32'hCAFE_F00D);
        chk("sticky_error", 32'(mon_error), 1);
        str_a(mk_a(1'b0, 1'b0, 1'b1, 8'h00));
        chk("clr_error", 32'(mon_error), 0);

        jdo = mk_a(1'b0, 1'b1, 1'b0, 8'h30);
        take_a = 1'b1;
        take_b = 1'b1;
        tick();
        take_a = 1'b0;
        take_b = 1'b0;
        chk("ab_error", 32'(mon_error), 1);
        tick();
        tick();
        chk("ab_areg", 32'(dut.mon_areg), 32'h30);
        str_a(mk_a(1'b0, 1'b0, 1'b1, 8'h00));

        for (int i = 0; i < 6; i++) jwrite(tbl[i].addr, tbl[i].data);
        for (int i = 0; i < 6; i++) begin
            jread(tbl[i].addr, d);
            chk($sformatf("tbl_rd_%0d", i), d, tbl[i].data);
        end
        chk("tbl_error", 32'(mon_error), 0);

        jwrite(8'h20, 32'h1234_5678);
        bus.avs_address = 8'h20;
        bus.avs_read = 1'b1;
        jdo = mk_a(1'b1, 1'b1, 1'b0, 8'h40);
        take_a = 1'b1;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest) break;
            cyc++;
            @(posedge clk);
            #1;
            take_a = 1'b0;
        end
        take_a = 1'b0;
        chk("cpu_coll_wait", 32'(cyc), 4);
        chk("cpu_coll_data", bus.avs_readdata, 32'h1234_5678);
        chk("cpu_coll_jtag", mon_dreg, 32'hA5A5_0001);
        @(posedge clk);
        #1;
        bus.avs_read = 1'b0;
        tick();

        cpu_write(8'h20, 32'h0000_AB00, 4'b0010);
        cpu_read(8'h20, d, cyc);
        chk("cpu_be_data", d, 32'h1234_AB78);
        chk("cpu_rd_wait", 32'(cyc), 1);
        jread(8'h20, d);
        chk("cpu_be_jtag", d, 32'h1234_AB78);

`ifdef OCIMEM_WRITE_PROTECT_EN
        jread(8'h03, v0);
        str_a(mk_a(1'b0, 1'b1, 1'b0, 8'h03));
        str_b(32'h55AA_55AA);
        tick();
        chk("prot_error", 32'(mon_error), 1);
        chk("prot_areg", 32'(dut.mon_areg), 32'h04);
        jread(8'h03, d);
        chk("prot_ram", d, v0);
        str_a(mk_a(1'b0, 1'b0, 1'b1, 8'h00));
        jread(8'h05, v0);
        cpu_write(8'h05, 32'hFFFF_FFFF, 4'hF);
        cpu_read(8'h05, d, cyc);
        chk("prot_cpu_ram", d, v0);
        chk("prot_cpu_error", 32'(mon_error), 0);
`else
        v0 = 32'h55AA_55AA;
        jwrite(8'h03, v0);
        jread(8'h03, d);
        chk("noprot_ram", d, v0);
        chk("noprot_error", 32'(mon_error), 0);
`endif

        str_a(mk_a(1'b1, 1'b1, 1'b0, 8'h40));
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_dreg", mon_dreg, 0);
        chk("rst_mid_ready", 32'(mon_ready), 0);
        chk("rst_mid_fsm", 32'(dut.state), 0);
        chk("rst_mid_readdata", bus.avs_readdata, 0);
        #4 reset_n = 1'b1;
        tick();
        chk("rst_mid_error", 32'(mon_error), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
